// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported data memory.
// The arbiter connects through the slave modport; the surrounding system uses the master modport.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        i_reqValid;
    logic [1:0]        i_reqWrite;
    logic [1:0]        i_reqLock;
    logic [ADDR_W-1:0] i_reqAddr  [2];
    logic [DATA_W-1:0] i_reqWdata [2];
    logic [1:0]        o_reqReady;
    logic [1:0]        o_rspValid;
    logic [DATA_W-1:0] o_rspData  [2];
    logic [ADDR_W-1:0] o_memAddress;
    logic              o_memWriteEnable;
    logic [DATA_W-1:0] o_memWriteData;
    logic [DATA_W-1:0] i_memReadData;

    modport slave (
        input  i_reqValid, i_reqWrite, i_reqLock, i_reqAddr, i_reqWdata, i_memReadData,
        output o_reqReady, o_rspValid, o_rspData, o_memAddress, o_memWriteEnable, o_memWriteData
    );

    modport master (
        output i_reqValid, i_reqWrite, i_reqLock, i_reqAddr, i_reqWdata, i_memReadData,
        input  o_reqReady, o_rspValid, o_rspData, o_memAddress, o_memWriteEnable, o_memWriteData
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin two-port arbiter in front of the 64-word data memory, with registered load responses.
// Optional grant locking is compiled in when DMEM_ARB_LOCK_EN is defined.
//
// lock state  | meaning
// UNLOCKED    | plain round-robin between both ports
// LOCKED0     | only port 0 may be granted
// LOCKED1     | only port 1 may be granted
module data_memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                  i_clk,
    input logic                  i_arstN,
    data_memory_arbiter_if.slave bus
);

    localparam logic [1:0] LK_UNLOCKED = 2'd0;
    localparam logic [1:0] LK_LOCKED0  = 2'd1;
    localparam logic [1:0] LK_LOCKED1  = 2'd2;

    logic              prio_q, prio_d;
    logic [1:0]        lock_q, lock_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q [2];
    logic [DATA_W-1:0] rsp_data_d [2];

    logic grant_raw;
    logic grant_any;
    logic grant_idx;

    always_comb begin
        grant_raw = 1'b0;
        grant_idx = 1'b0;
        case (lock_q)
            LK_LOCKED0: begin
                grant_raw = bus.i_reqValid[0];
                grant_idx = 1'b0;
            end
            LK_LOCKED1: begin
                grant_raw = bus.i_reqValid[1];
                grant_idx = 1'b1;
            end
            default: begin
                grant_raw = |bus.i_reqValid;
                if (&bus.i_reqValid) grant_idx = prio_q;
                else                 grant_idx = bus.i_reqValid[1];
            end
        endcase
    end

    // Reset gates the grant combinationally so no write can reach memory while i_arstN is low.
    assign grant_any = grant_raw & i_arstN;

    assign bus.o_reqReady       = grant_any ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.o_memAddress     = grant_any ? bus.i_reqAddr[grant_idx]  : '0;
    assign bus.o_memWriteData   = grant_any ? bus.i_reqWdata[grant_idx] : '0;
    assign bus.o_memWriteEnable = grant_any & bus.i_reqWrite[grant_idx];

    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        if (grant_any) begin
            if (lock_q == LK_UNLOCKED) prio_d = ~grant_idx;
            if (!bus.i_reqWrite[grant_idx]) begin
                rsp_valid_d[grant_idx] = 1'b1;
                rsp_data_d[grant_idx]  = bus.i_memReadData;
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (grant_any) begin
            if (bus.i_reqLock[grant_idx]) lock_d = grant_idx ? LK_LOCKED1 : LK_LOCKED0;
            else                          lock_d = LK_UNLOCKED;
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^bus.i_reqLock;

    always_comb begin
        lock_d = LK_UNLOCKED;
    end
`endif

    always_ff @(posedge i_clk or negedge i_arstN) begin
        if (!i_arstN) begin
            prio_q      <= 1'b0;
            lock_q      <= LK_UNLOCKED;
            rsp_valid_q <= 2'b00;
            for (int k = 0; k < 2; k++) rsp_data_q[k] <= '0;
        end else begin
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            rsp_valid_q <= rsp_valid_d;
            for (int k = 0; k < 2; k++) rsp_data_q[k] <= rsp_data_d[k];
        end
    end

    assign bus.o_rspValid   = rsp_valid_q;
    assign bus.o_rspData[0] = rsp_data_q[0];
    assign bus.o_rspData[1] = rsp_data_q[1];

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios followed by random traffic,
// compared against a behavioural model of the arbitration rules and the memory contents.
module tb_data_memory_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic i_clk;
    logic i_arstN;

    data_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk   (i_clk),
        .i_arstN (i_arstN),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory environment: combinational read, write committed at the end of the grant cycle.
    logic [DATA_W-1:0] mem_array [64];
    assign bus.i_memReadData = mem_array[bus.o_memAddress[7:2]];
    always @(posedge i_clk) begin
        if (bus.o_memWriteEnable) mem_array[bus.o_memAddress[7:2]] <= bus.o_memWriteData;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] model_mem [64];
    int                m_prio;
    int                m_lock;   // 0 unlocked, 1 owned by port 0, 2 owned by port 1
    logic [1:0]        m_rv;
    logic [DATA_W-1:0] m_rd [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input bit v, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input bit lk);
        bus.i_reqValid[k] = v;
        bus.i_reqWrite[k] = w;
        bus.i_reqAddr[k]  = a;
        bus.i_reqWdata[k] = d;
        bus.i_reqLock[k]  = lk;
    endtask

    task automatic clear_reqs();
        set_req(0, 0, 0, 32'h0, 32'h0, 0);
        set_req(1, 0, 0, 32'h0, 32'h0, 0);
    endtask

    function automatic int model_grant();
        bit v0, v1;
        v0 = bus.i_reqValid[0];
        v1 = bus.i_reqValid[1];
        if (m_lock == 1) return v0 ? 0 : -1;
        if (m_lock == 2) return v1 ? 1 : -1;
        if (v0 && v1) return m_prio;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // One clock cycle: check combinational grant/memory drive, advance the model, check responses.
    task automatic do_cycle(output int g);
        int          eg;
        logic        cw, clk_lock;
        logic [31:0] ca, cd;
        @(negedge i_clk);
        eg = model_grant();
        cw = 0; ca = 0; cd = 0; clk_lock = 0;
        if (eg >= 0) begin
            cw       = bus.i_reqWrite[eg];
            ca       = bus.i_reqAddr[eg];
            cd       = bus.i_reqWdata[eg];
            clk_lock = bus.i_reqLock[eg];
        end
        check("ready", bus.o_reqReady, (eg < 0) ? 2'b00 : 2'(1 << eg));
        check("mem_we", bus.o_memWriteEnable, cw);
        check("mem_addr", bus.o_memAddress, ca);
        check("mem_wdata", bus.o_memWriteData, cd);
        @(posedge i_clk);
        m_rv = 2'b00;
        if (eg >= 0) begin
            if (cw) model_mem[ca[7:2]] = cd;
            else begin
                m_rv[eg] = 1'b1;
                m_rd[eg] = model_mem[ca[7:2]];
            end
`ifdef DMEM_ARB_LOCK_EN
            if (m_lock == 0) m_prio = 1 - eg;
            m_lock = clk_lock ? eg + 1 : 0;
`else
            m_prio = 1 - eg;
`endif
        end
        #1;
        check("rsp_valid", bus.o_rspValid, m_rv);
        check("rsp_data0", bus.o_rspData[0], m_rd[0]);
        check("rsp_data1", bus.o_rspData[1], m_rd[1]);
        g = eg;
    endtask

    task automatic apply_reset(input bit drive_junk);
        i_arstN = 1'b0;
        #1;
        check("rst_rsp_valid", bus.o_rspValid, 2'b00);
        check("rst_rsp_data0", bus.o_rspData[0], 32'h0);
        check("rst_rsp_data1", bus.o_rspData[1], 32'h0);
        if (drive_junk) begin
            set_req(0, 1, 1, 32'h0000_003C, 32'hBAD0_BAD0, 1);
            set_req(1, 1, 1, 32'h0000_003C, 32'hBAD1_BAD1, 1);
        end
        @(negedge i_clk);
        check("rst_ready", bus.o_reqReady, 2'b00);
        check("rst_mem_we", bus.o_memWriteEnable, 1'b0);
        @(posedge i_clk);
        #1;
        check("rst_no_write", mem_array[15], model_mem[15]);
        clear_reqs();
        m_prio = 0;
        m_lock = 0;
        m_rv   = 2'b00;
        m_rd[0] = '0;
        m_rd[1] = '0;
        @(negedge i_clk);
        i_arstN = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int g;
        int n1;
        int last_c;
        int expg;
        bit p0_busy;
        for (int i = 0; i < 64; i++) begin
            mem_array[i] = '0;
            model_mem[i] = '0;
        end
        i_arstN = 1'b0;
        clear_reqs();
        apply_reset(1);

        // Store then load on port 0
        set_req(0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        do_cycle(g);
        set_req(0, 1, 0, 32'h0000_0010, 32'h0, 0);
        do_cycle(g);
        clear_reqs();
        check("t1_rsp_valid", bus.o_rspValid, 2'b01);
        check("t1_rsp_data0", bus.o_rspData[0], 32'hDEAD_BEEF);
        do_cycle(g);

        // Preload 0x20/0x24, then both ports load continuously after reset
        set_req(0, 1, 1, 32'h0000_0020, 32'hA1A1_0020, 0);
        do_cycle(g);
        set_req(0, 1, 1, 32'h0000_0024, 32'hB2B2_0024, 0);
        do_cycle(g);
        clear_reqs();
        apply_reset(0);
        set_req(0, 1, 0, 32'h0000_0020, 32'h0, 0);
        set_req(1, 1, 0, 32'h0000_0024, 32'h0, 0);
        for (int c = 0; c < 6; c++) begin
            do_cycle(g);
            check("alt_grant", 64'(g), 64'(c % 2));
            check("alt_rsp_data", bus.o_rspData[c % 2], (c % 2 == 0) ? 32'hA1A1_0020 : 32'hB2B2_0024);
        end
        clear_reqs();

        // Store on port 1 followed by load of the same word on port 0
        set_req(1, 1, 1, 32'h0000_0008, 32'h1234_5678, 0);
        do_cycle(g);
        clear_reqs();
        set_req(0, 1, 0, 32'h0000_0008, 32'h0, 0);
        do_cycle(g);
        clear_reqs();
        check("raw_rsp_valid", bus.o_rspValid, 2'b01);
        check("raw_rsp_data0", bus.o_rspData[0], 32'h1234_5678);

        // Reset in the cycle after a granted load
        set_req(0, 1, 0, 32'h0000_0010, 32'h0, 0);
        do_cycle(g);
        check("pre_rst_rsp_valid", bus.o_rspValid, 2'b01);
        apply_reset(1);
        set_req(0, 1, 0, 32'h0000_0010, 32'h0, 0);
        set_req(1, 1, 0, 32'h0000_0020, 32'h0, 0);
        do_cycle(g);
        check("post_rst_winner", 64'(g), 64'd0);
        clear_reqs();
        do_cycle(g);

        // Lock scenario: port 1 has priority, issues 3 locked loads then an unlocked one
        set_req(0, 1, 0, 32'h0000_0004, 32'h0, 0);
        do_cycle(g);
        n1 = 0;
        set_req(0, 1, 0, 32'h0000_0010, 32'h0, 0);
        set_req(1, 1, 0, 32'h0000_0020, 32'h0, 1);
`ifdef DMEM_ARB_LOCK_EN
        last_c = 5;
`else
        last_c = 8;
`endif
        for (int c = 0; c < last_c; c++) begin
`ifdef DMEM_ARB_LOCK_EN
            expg = (c < 4) ? 1 : 0;
`else
            expg = (c % 2 == 0) ? 1 : 0;
`endif
            do_cycle(g);
            check("lock_grant", 64'(g), 64'(expg));
            if (g == 1) begin
                n1++;
                if (n1 < 4) set_req(1, 1, 0, 32'h0000_0020, 32'h0, (n1 < 3));
                else        set_req(1, 0, 0, 32'h0, 32'h0, 0);
            end
        end
        clear_reqs();

        // Idle cycles
        for (int c = 0; c < 5; c++) begin
            do_cycle(g);
            check("idle_grant", 64'(g), -64'sd1);
            check("idle_mem_addr", bus.o_memAddress, 32'h0);
        end

        // Random traffic; requesters hold their request until it transfers
        p0_busy = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                clear_reqs();
                apply_reset(1);
            end
            for (int k = 0; k < 2; k++) begin
                if (!bus.i_reqValid[k] && ($urandom % 2 == 0))
                    set_req(k, 1, $urandom % 2, $urandom, $urandom, ($urandom % 4 == 0));
            end
            do_cycle(g);
            if (g >= 0) begin
                if ($urandom % 4 != 0)
                    set_req(g, 1, $urandom % 2, $urandom, $urandom, ($urandom % 4 == 0));
                else
                    set_req(g, 0, 0, 32'h0, 32'h0, 0);
            end
        end
        clear_reqs();
        do_cycle(g);
        check("final_mem_sync", mem_array[4], model_mem[4]);
        if (p0_busy) check("unused", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
